// File: rtl/sti_receiver_if.sv
// Bundle of configuration, serial-link and parallel-output signals of the STI receiver.
// Handshake: si_data is meaningful only in a cycle where si_valid=1, and a frame's
// bits arrive in consecutive si_valid cycles. po_valid is a one-cycle pulse with no
// ready; po_data/po_mask/pad_err are qualified by it and hold until the next pulse.
// cfg_load takes effect only in a cycle where busy=0 and si_valid=0.
interface sti_receiver_if;
    logic        cfg_load;
    logic [1:0]  cfg_length;
    logic        cfg_fill;
    logic        cfg_msb;
    logic        cfg_low;
    logic        si_data;
    logic        si_valid;
    logic [15:0] po_data;
    logic [1:0]  po_mask;
    logic        po_valid;
    logic        pad_err;
    logic        frame_err;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        dbg_rx_state;   // 0=IDLE, 1=RX

    // Receiver side
    modport slave (
        input  cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low, si_data, si_valid,
        output po_data, po_mask, po_valid, pad_err, frame_err, busy, frame_cnt,
               dbg_rx_state
    );

    // Stimulus / link side
    modport master (
        output cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low, si_data, si_valid,
        input  po_data, po_mask, po_valid, pad_err, frame_err, busy, frame_cnt,
               dbg_rx_state
    );
endinterface

// File: rtl/sti_receiver.sv
// STI serial-to-parallel receiver: samples a framed bit stream, rebuilds the 16-bit
// word according to the frame configuration, checks padding and counts good frames.
module sti_receiver (
    input  logic           clk,
    input  logic           reset,
    sti_receiver_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] shreg_q, shreg_d;

    logic [1:0]  cfg_length_q;
    logic        cfg_fill_q;
    logic        cfg_msb_q;
    logic        cfg_low_q;

    logic [15:0] po_data_q;
    logic [1:0]  po_mask_q;
    logic        po_valid_q;
    logic        pad_err_q;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  frame_cnt_q;

    logic        sample;
    logic        out_load;
    logic        cfg_accept;
    logic [4:0]  last_idx;
    logic [4:0]  win_shift;
    logic [31:0] shreg_next;
    logic [31:0] frame;
    logic [15:0] ext_data;
    logic [1:0]  ext_mask;
    logic        ext_pad;

    // Index of the final bit of a frame (N-1) and the right shift that brings an
    // LSB-first window (top N bits of the register) down to bit 0 (32-N).
    assign last_idx  = {cfg_length_q, 3'b111};
    assign win_shift = {~cfg_length_q, 3'b000};

    assign cfg_accept = bus.cfg_load && (state_q == ST_IDLE) && !bus.si_valid;

    // Shift register after taking the current bit in the configured direction.
    assign shreg_next = cfg_msb_q ? {shreg_q[30:0], bus.si_data}
                                  : {bus.si_data, shreg_q[31:1]};

    // Frame bits F[N-1:0] aligned to bit 0, taken from the register as it will be
    // once the last bit is in.
    assign frame = cfg_msb_q ? shreg_next : (shreg_next >> win_shift);

    // Word extraction and padding check for the configured length/fill/lane.
    always_comb begin
        ext_data = frame[15:0];
        ext_mask = 2'b11;
        ext_pad  = 1'b0;
        case (cfg_length_q)
            2'b00: begin
                if (cfg_low_q) begin
                    ext_data = {8'h00, frame[7:0]};
                    ext_mask = 2'b01;
                end else begin
                    ext_data = {frame[7:0], 8'h00};
                    ext_mask = 2'b10;
                end
            end
            2'b01: begin
                ext_data = frame[15:0];
            end
            2'b10: begin
                if (cfg_fill_q) begin
                    ext_data = frame[15:0];
                    ext_pad  = |frame[23:16];
                end else begin
                    ext_data = frame[23:8];
                    ext_pad  = |frame[7:0];
                end
            end
            default: begin
                if (cfg_fill_q) begin
                    ext_data = frame[15:0];
                    ext_pad  = |frame[31:16];
                end else begin
                    ext_data = frame[31:16];
                    ext_pad  = |frame[15:0];
                end
            end
        endcase
    end

    // Next-state logic: bit sampling, frame completion and truncation detection.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        sample      = 1'b0;
        out_load    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.si_valid) begin
                    sample  = 1'b1;
                    count_d = 5'd1;
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                if (bus.si_valid) begin
                    sample = 1'b1;
                    if (count_q == last_idx) begin
                        count_d  = 5'd0;
                        out_load = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    count_d     = 5'd0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 5'd0;
            end
        endcase
        if (sample) begin
            shreg_d = shreg_next;
        end
    end

    // State, shift register and configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 5'd0;
            shreg_q      <= 32'd0;
            cfg_length_q <= 2'b00;
            cfg_fill_q   <= 1'b0;
            cfg_msb_q    <= 1'b0;
            cfg_low_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            if (cfg_accept) begin
                cfg_length_q <= bus.cfg_length;
                cfg_fill_q   <= bus.cfg_fill;
                cfg_msb_q    <= bus.cfg_msb;
                cfg_low_q    <= bus.cfg_low;
            end
        end
    end

    // Output word, status pulses and the saturating good-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            po_data_q   <= 16'd0;
            po_mask_q   <= 2'b00;
            po_valid_q  <= 1'b0;
            pad_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            po_valid_q  <= out_load;
            frame_err_q <= frame_err_d;
            if (out_load) begin
                po_data_q <= ext_data;
                po_mask_q <= ext_mask;
                pad_err_q <= ext_pad;
                if (frame_cnt_q != 8'hFF) begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.po_data      = po_data_q;
    assign bus.po_mask      = po_mask_q;
    assign bus.po_valid     = po_valid_q;
    assign bus.pad_err      = pad_err_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.busy         = (state_q == ST_RX);
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.dbg_rx_state = state_q;

endmodule

// File: tb/tb_sti_receiver.sv
// Directed bench for sti_receiver with a scoreboard of expected output words.
module tb_sti_receiver;

    logic clk;
    logic reset;

    sti_receiver_if ifc ();

    sti_receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int errors = 0;
    int checks = 0;

    // Expected word entries: {po_data, po_mask, pad_err}
    logic [18:0] exp_q[$];

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic push_exp(input logic [15:0] d, input logic [1:0] m, input logic p);
        exp_q.push_back({d, m, p});
    endtask

    task automatic do_cfg(input logic [1:0] len, input logic fill, input logic msb,
                          input logic low);
        ifc.si_valid   = 1'b0;
        ifc.cfg_length = len;
        ifc.cfg_fill   = fill;
        ifc.cfg_msb    = msb;
        ifc.cfg_low    = low;
        ifc.cfg_load   = 1'b1;
        tick();
        ifc.cfg_load   = 1'b0;
    endtask

    // Sends bits [first, last) of an n-bit frame in the given order.
    task automatic send_bits(input logic [31:0] f, input int n, input logic msb,
                             input int first, input int last);
        for (int i = first; i < last; i++) begin
            ifc.si_valid = 1'b1;
            ifc.si_data  = msb ? f[n-1-i] : f[i];
            tick();
        end
    endtask

    // Sends a whole frame and checks the po_valid pulse lands right after the last bit.
    task automatic send_frame(input logic [31:0] f, input int n, input logic msb,
                              input logic keep_valid, input string tag);
        send_bits(f, n, msb, 0, n);
        if (!keep_valid) ifc.si_valid = 1'b0;
        check({tag, "_po_valid"}, 32'(ifc.po_valid), 32'd1);
    endtask

    // Scoreboard: pop an expectation on every po_valid pulse.
    always @(negedge clk) begin
        if (!reset && ifc.po_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_po_valid", 32'd1, 32'd0);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("sb_po_data", 32'(ifc.po_data), 32'(e[18:3]));
                check("sb_po_mask", 32'(ifc.po_mask), 32'(e[2:1]));
                check("sb_pad_err", 32'(ifc.pad_err), 32'(e[0]));
            end
        end
    end

    initial begin
        ifc.cfg_load   = 1'b0;
        ifc.cfg_length = 2'b00;
        ifc.cfg_fill   = 1'b0;
        ifc.cfg_msb    = 1'b0;
        ifc.cfg_low    = 1'b0;
        ifc.si_data    = 1'b0;
        ifc.si_valid   = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_po_data",   32'(ifc.po_data),   32'd0);
        check("rst_po_mask",   32'(ifc.po_mask),   32'd0);
        check("rst_po_valid",  32'(ifc.po_valid),  32'd0);
        check("rst_pad_err",   32'(ifc.pad_err),   32'd0);
        check("rst_frame_err", 32'(ifc.frame_err), 32'd0);
        check("rst_busy",      32'(ifc.busy),      32'd0);
        check("rst_frame_cnt", 32'(ifc.frame_cnt), 32'd0);

        // 16-bit MSB-first
        do_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        push_exp(16'hA5C3, 2'b11, 1'b0);
        send_frame(32'hA5C3, 16, 1'b1, 1'b0, "a5c3");
        check("a5c3_cnt", 32'(ifc.frame_cnt), 32'd1);
        tick();
        check("a5c3_pulse_end", 32'(ifc.po_valid), 32'd0);
        check("a5c3_hold", 32'(ifc.po_data), 32'hA5C3);

        // 8-bit LSB-first, low then high lane
        do_cfg(2'b00, 1'b0, 1'b0, 1'b1);
        push_exp(16'h003C, 2'b01, 1'b0);
        send_frame(32'h3C, 8, 1'b0, 1'b0, "b3c_low");
        tick();
        do_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        push_exp(16'h3C00, 2'b10, 1'b0);
        send_frame(32'h3C, 8, 1'b0, 1'b0, "b3c_high");
        tick();

        // 32-bit, data in MSBs, clean then dirty padding
        do_cfg(2'b11, 1'b0, 1'b1, 1'b0);
        push_exp(16'h1234, 2'b11, 1'b0);
        send_frame(32'h1234_0000, 32, 1'b1, 1'b0, "w32_clean");
        tick();
        push_exp(16'h1234, 2'b11, 1'b1);
        send_frame(32'h1234_0001, 32, 1'b1, 1'b0, "w32_pad");
        check("w32_pad_cnt", 32'(ifc.frame_cnt), 32'd5);
        tick();

        // 24-bit, data in LSBs, LSB-first
        do_cfg(2'b10, 1'b1, 1'b0, 1'b0);
        push_exp(16'hBEEF, 2'b11, 1'b0);
        send_frame(32'h00BEEF, 24, 1'b0, 1'b0, "w24_fill1");
        tick();

        // 24-bit, data in MSBs, padding 0x80 is non-zero
        do_cfg(2'b10, 1'b0, 1'b1, 1'b0);
        push_exp(16'hCAFE, 2'b11, 1'b1);
        send_frame(32'hCAFE80, 24, 1'b1, 1'b0, "w24_fill0");
        check("w24_cnt", 32'(ifc.frame_cnt), 32'd7);
        tick();

        // Truncated 16-bit frame, then a good one
        do_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        send_bits(32'hFFFF, 16, 1'b1, 0, 5);
        check("trunc_busy_mid", 32'(ifc.busy), 32'd1);
        ifc.si_valid = 1'b0;
        tick();
        check("trunc_frame_err", 32'(ifc.frame_err), 32'd1);
        check("trunc_busy", 32'(ifc.busy), 32'd0);
        check("trunc_no_valid", 32'(ifc.po_valid), 32'd0);
        tick();
        check("trunc_err_end", 32'(ifc.frame_err), 32'd0);
        check("trunc_cnt", 32'(ifc.frame_cnt), 32'd7);
        push_exp(16'h0F0F, 2'b11, 1'b0);
        send_frame(32'h0F0F, 16, 1'b1, 1'b0, "after_trunc");
        tick();

        // Back-to-back 8-bit frames with si_valid held high
        do_cfg(2'b00, 1'b0, 1'b1, 1'b1);
        push_exp(16'h0081, 2'b01, 1'b0);
        push_exp(16'h007E, 2'b01, 1'b0);
        send_frame(32'h81, 8, 1'b1, 1'b1, "b2b_first");
        send_frame(32'h7E, 8, 1'b1, 1'b0, "b2b_second");
        check("b2b_cnt", 32'(ifc.frame_cnt), 32'd10);
        tick();

        // Reset at bit 10 of a 16-bit frame, with non-zero config
        do_cfg(2'b01, 1'b1, 1'b1, 1'b1);
        send_bits(32'hFFFF, 16, 1'b1, 0, 10);
        ifc.si_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_po_data",   32'(ifc.po_data),   32'd0);
        check("mrst_po_mask",   32'(ifc.po_mask),   32'd0);
        check("mrst_po_valid",  32'(ifc.po_valid),  32'd0);
        check("mrst_frame_err", 32'(ifc.frame_err), 32'd0);
        check("mrst_busy",      32'(ifc.busy),      32'd0);
        check("mrst_frame_cnt", 32'(ifc.frame_cnt), 32'd0);
        tick();
        check("mrst_no_err", 32'(ifc.frame_err), 32'd0);
        // Config back to zero: 8-bit, LSB-first, high lane
        push_exp(16'h5A00, 2'b10, 1'b0);
        send_frame(32'h5A, 8, 1'b0, 1'b0, "mrst_cfg0");
        tick();

        // cfg_load while busy is ignored
        do_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        push_exp(16'hC0DE, 2'b11, 1'b0);
        send_bits(32'hC0DE, 16, 1'b1, 0, 3);
        ifc.cfg_length = 2'b11;
        ifc.cfg_load   = 1'b1;
        send_bits(32'hC0DE, 16, 1'b1, 3, 4);
        ifc.cfg_load   = 1'b0;
        send_bits(32'hC0DE, 16, 1'b1, 4, 16);
        ifc.si_valid = 1'b0;
        check("busy_cfg_po_valid", 32'(ifc.po_valid), 32'd1);
        tick();
        push_exp(16'h1357, 2'b11, 1'b0);
        send_frame(32'h1357, 16, 1'b1, 1'b0, "busy_cfg_next");
        tick();
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
